gate_bank_checker: RTL

- Sequential stimulus-and-check stage wrapped around the 6-output mux-built gate bank.
- Upstream role: drives the bank's A/B inputs through all four input vectors.
- Downstream role: samples the bank's O[5:0] after a programmable settle time and compares it with the expected truth table.
- Reports per-gate sticky error bits, a mismatch count and pass/done status; used as the self-check block on the board/bench.

---
 rtl/gate_bank_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gate_bank_checker.sv
// Stimulus-and-check stage for the 6-output gate bank: steps A/B through all four
// vectors, samples gate_o after a settle time and reports sticky errors.
// Optional build macro GATE_CHECK_ABORT_EN: stop the scan at the first mismatching vector.
module gate_bank_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic [5:0] gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  // Gate order: [0]AND [1]OR [2]NOT(A) [3]NAND [4]XOR [5]XNOR, with A=v[1], B=v[0].
  function automatic logic [5:0] expected_out(input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    return {~(a ^ b), a ^ b, ~(a & b), ~a, a | b, a & b};
  endfunction

  logic [1:0] state_q,      state_d;
  logic [1:0] vec_q,        vec_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       gate_a_q,     gate_a_d;
  logic       gate_b_q,     gate_b_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;
  logic       pass_q,       pass_d;
  logic [5:0] err_mask_q,   err_mask_d;
  logic [2:0] err_count_q,  err_count_d;
  logic [1:0] fail_vec_q,   fail_vec_d;

  logic [5:0] mism;
  logic       last_vec;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    pass_d       = pass_q;
    err_mask_d   = err_mask_q;
    err_count_d  = err_count_q;
    fail_vec_d   = fail_vec_q;

    mism     = gate_o ^ expected_out(vec_q);
    last_vec = (vec_q == 2'd3);
`ifdef GATE_CHECK_ABORT_EN
    last_vec = last_vec | (|mism);
`else
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d        = 2'd0;
          settle_cnt_d = SETTLE_INIT;
          pass_d       = 1'b0;
          err_mask_d   = 6'd0;
          err_count_d  = 3'd0;
          fail_vec_d   = 2'd0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q - 4'd1;
        if (settle_cnt_q <= 4'd1) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        err_mask_d = err_mask_q | mism;
        if (|mism) begin
          err_count_d = err_count_q + 3'd1;
          if (err_count_q == 3'd0) begin
            fail_vec_d = vec_q;
          end
        end
        if (last_vec) begin
          // Verdict uses the mask including this vector so pass is valid in REPORT.
          pass_d  = ((err_mask_q | mism) == 6'd0);
          state_d = S_REPORT;
        end else begin
          vec_d        = vec_q + 2'd1;
          settle_cnt_d = SETTLE_INIT;
          state_d      = S_SETTLE;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    gate_a_d = vec_d[1];
    gate_b_d = vec_d[0];
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= 2'd0;
      settle_cnt_q <= 4'd0;
      gate_a_q     <= 1'b0;
      gate_b_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= 6'd0;
      err_count_q  <= 3'd0;
      fail_vec_q   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      gate_a_q     <= gate_a_d;
      gate_b_q     <= gate_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_mask_q   <= err_mask_d;
      err_count_q  <= err_count_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
